// File: rtl/clock_select_pkg.sv
// Shared definitions for the clock-select controller.
//   state_e    : controller state encoding
//   cnt_width  : width of the shared phase timer
//   DEF_*      : default parameter values
package clock_select_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOCK_WAIT,
    GATE_OFF,
    SETTLE,
    ACK
  } state_e;

  localparam int   DEF_GATE_CYCLES   = 4;
  localparam int   DEF_SETTLE_CYCLES = 8;
  localparam logic DEF_RESET_SELECT  = 1'b1;
  localparam int   DEF_LOCK_TIMEOUT  = 1024;

  // The timer must be able to hold the longest of the three phase lengths.
  function automatic int cnt_width(input int gate_c, input int settle_c, input int lock_c);
    int m;
    m = gate_c;
    if (settle_c > m) m = settle_c;
    if (lock_c > m) m = lock_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clock_select_timer.sv
// Loadable down-counter shared by the timed controller phases.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : phase length minus one
//   done      : counter has reached zero
module clock_select_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/clock_select_ctrl.sv
// Glitch-free select driver for a two-input clock mux (select=1 -> clk_input0).
// A switch request gates the downstream clock off, changes select, waits for
// the mux output to settle, re-enables the gate and pulses switch_ack.
//   clk, rst                  : always-on reference clock, sync active-high reset
//   switch_req/switch_target  : request handshake (accepted when switch_ready)
//   switch_ready, switch_ack  : idle indicator, one-cycle completion pulse
//   busy, select, clk_gate_en : status and registered mux/gate controls
// Optional macro CLOCK_SELECT_CTRL_LOCK_CHECK_EN adds target_locked/switch_error
// and a LOCK_WAIT phase that waits for the target source to lock before gating.
import clock_select_pkg::*;

module clock_select_ctrl #(
  parameter int   GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic RESET_SELECT  = DEF_RESET_SELECT,
  parameter int   LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_req,
  input  logic switch_target,
  output logic switch_ready,
  output logic switch_ack,
  output logic busy,
  output logic select,
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
  input  logic target_locked,
  output logic switch_error,
`endif
  output logic clk_gate_en
);

  localparam int CW = cnt_width(GATE_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT);

  state_e        state_q, state_d;
  logic          target_q, target_d;
  logic          select_q, select_d;
  logic          gate_q, gate_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
  logic          err_q, err_d;
`endif

  assign accept = switch_req && (state_q == IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= RESET_SELECT;
      select_q <= RESET_SELECT;
      gate_q   <= 1'b1;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      select_q <= select_d;
      gate_q   <= gate_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = switch_target;
          if (switch_target == select_q) state_d = ACK;
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
          else                           state_d = LOCK_WAIT;
`else
          else                           state_d = GATE_OFF;
`endif
        end
      end
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
      LOCK_WAIT: begin
        if (target_locked) state_d = GATE_OFF;
        else if (tmr_done) state_d = ACK;
      end
`endif
      GATE_OFF: if (tmr_done) state_d = SETTLE;
      SETTLE:   if (tmr_done) state_d = ACK;
      ACK:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    select_d = select_q;
    if (state_q == GATE_OFF && state_d == SETTLE) select_d = target_q;
    gate_d = !(state_d == GATE_OFF || state_d == SETTLE);
    ack_d  = (state_d == ACK);
    busy_d = (state_d != IDLE);
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
    err_d = err_q;
    if (accept) err_d = 1'b0;
    // Leaving LOCK_WAIT straight to ACK means the lock never arrived.
    if (state_q == LOCK_WAIT && state_d == ACK) err_d = 1'b1;
`endif
  end

  // Timer reloads on every state entry with the new phase length minus one.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      LOCK_WAIT: tmr_val = CW'(LOCK_TIMEOUT - 1);
      GATE_OFF:  tmr_val = CW'(GATE_CYCLES - 1);
      SETTLE:    tmr_val = CW'(SETTLE_CYCLES - 1);
      default:   tmr_val = '0;
    endcase
  end

  clock_select_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign switch_ready = (state_q == IDLE);
  assign switch_ack   = ack_q;
  assign busy         = busy_q;
  assign select       = select_q;
  assign clk_gate_en  = gate_q;
`ifdef CLOCK_SELECT_CTRL_LOCK_CHECK_EN
  assign switch_error = err_q;
`endif

endmodule
